// File: rtl/dma_seq_ctrl.sv
// DMA sequencer: one word-by-word transfer per DMA instruction over a single bus master.
// Optional completion interrupt is built only when DMA_IRQ_EN is defined.
module dma_seq_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0004_0000,
    parameter logic [31:0] IO_LAST = 32'h0004_7FFF,
    parameter int unsigned LEN_W   = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] byte_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_wstrb_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic             irq_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [29:0]      src_q, src_d;
    logic [29:0]      dst_q, dst_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [1:0]       tail_q, tail_d;
    logic [31:0]      data_q, data_d;

    logic [LEN_W-1:0] len_rnd;
    logic [LEN_W-1:0] words_new;
    logic             last_word;
    logic [3:0]       strb_last;
    logic             unused_lsb;

    // Word count rounds the byte length up within the length field width.
    assign len_rnd   = byte_len_i + LEN_W'(3);
    assign words_new = len_rnd >> 2;
    assign last_word = (words_q == LEN_W'(1));
    assign unused_lsb = ^{src_addr_i[1:0], dst_addr_i[1:0]};

    // Partial strobe for the final word of a transfer whose length is not a word multiple.
    always_comb begin
        strb_last = 4'b1111;
        unique case (tail_q)
            2'd1:    strb_last = 4'b0001;
            2'd2:    strb_last = 4'b0011;
            2'd3:    strb_last = 4'b0111;
            default: strb_last = 4'b1111;
        endcase
    end

    // FIFO-style IO ports keep their address; everything else steps one word.
    function automatic logic in_io(input logic [29:0] w);
        logic [31:0] a;
        a = {w, 2'b00};
        return (a >= IO_BASE) && (a <= IO_LAST);
    endfunction

    // Next-state and bus outputs; outputs are decoded from the current state only.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        words_d     = words_q;
        tail_d      = tail_q;
        data_d      = data_q;
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wstrb_o = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i[31:2];
                    dst_d   = dst_addr_i[31:2];
                    words_d = words_new;
                    tail_d  = byte_len_i[1:0];
                    state_d = (words_new != '0) ? S_RD : S_DONE;
                end
            end
            S_RD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {src_q, 2'b00};
                if (mem_gnt_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    data_d  = mem_rdata_i;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {dst_q, 2'b00};
                mem_wstrb_o = last_word ? strb_last : 4'b1111;
                if (mem_gnt_i) begin
                    words_d = words_q - LEN_W'(1);
                    src_d   = in_io(src_q) ? src_q : src_q + 30'd1;
                    dst_d   = in_io(dst_q) ? dst_q : dst_q + 30'd1;
                    state_d = last_word ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_wdata_o = data_q;

    // Sequencer state and transfer bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            words_q <= '0;
            tail_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            words_q <= words_d;
            tail_q  <= tail_d;
            data_q  <= data_d;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_q, irq_d;

    // Sticky completion flag: cleared by an accepted start, set on entry to DONE.
    always_comb begin
        irq_d = irq_q;
        if ((state_q == S_IDLE) && start_i) begin
            irq_d = 1'b0;
        end
        if (state_d == S_DONE) begin
            irq_d = 1'b1;
        end
    end

    // Interrupt register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule
